mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port synchronous RAM.
// Data has priority over fetch, with a starve counter that guarantees fetch progress.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rstn,
  // fetch port
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  output logic              i_err,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              d_err,
  // RAM port
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [31:0]       ram_dina,
  input  logic [31:0]       ram_douta
);

  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StRespI, StRespD} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              starved, grant_i, grant_d, i_aligned, d_aligned;

  // Upper address bits alias away by design.
  logic unused_addr;
  assign unused_addr = ^{i_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

  assign i_aligned = (i_addr[1:0] == 2'b00);
  assign d_aligned = (d_addr[1:0] == 2'b00);
  assign starved   = (cnt_q == CntW'(STARVE_LIMIT));
  assign grant_d   = d_req && !(i_req && starved);
  assign grant_i   = i_req && !grant_d;

  assign i_rdata = rstn ? ram_douta : 32'h0;
  assign d_rdata = rstn ? ram_douta : 32'h0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = grant_d ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
    ram_dina  = d_wdata;
    i_ack     = 1'b0;
    i_err     = 1'b0;
    d_ack     = 1'b0;
    d_err     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Misaligned winners still take the response slot, but never touch the RAM.
        if (grant_d) begin
          state_d = StRespD;
          err_d   = !d_aligned;
          ram_ena = d_aligned;
          ram_wea = d_aligned && d_we;
        end else if (grant_i) begin
          state_d = StRespI;
          err_d   = !i_aligned;
          ram_ena = i_aligned;
        end
        if (!i_req || grant_i) begin
          cnt_d = '0;
        end else if (grant_d && !starved) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRespI: begin
        i_ack   = 1'b1;
        i_err   = err_q;
        state_d = StIdle;
      end
      StRespD: begin
        d_ack   = 1'b1;
        d_err   = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (!rstn) begin
      ram_ena = 1'b0;
      ram_wea = 1'b0;
      i_ack   = 1'b0;
      i_err   = 1'b0;
      d_ack   = 1'b0;
      d_err   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural synchronous RAM.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rstn;
  logic              i_req, i_ack, i_err;
  logic [31:0]       i_addr, i_rdata;
  logic              d_req, d_we, d_ack, d_err;
  logic [31:0]       d_addr, d_wdata, d_rdata;
  logic              ram_ena, ram_wea;
  logic [ADDR_W-1:0] ram_addra;
  logic [31:0]       ram_dina, ram_douta;

  logic [31:0] mem [0:15];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .d_err     (d_err),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_douta (ram_douta)
  );

  // Word 2 is preloaded while reset is held.
  always @(posedge clk) begin
    if (!rstn) begin
      mem[2] <= 32'h2402_0005;
    end else if (ram_ena) begin
      if (ram_wea) mem[ram_addra[3:0]] <= ram_dina;
      else         ram_douta <= mem[ram_addra[3:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One contention round: both/one requesting in IDLE, then check who was acked.
  task automatic grant_round(input string tag, input logic ireq, input logic exp_d);
    i_req  = ireq;
    d_req  = 1'b1;
    d_we   = 1'b0;
    i_addr = 32'h8;
    d_addr = 32'h10;
    @(negedge clk);
    check({tag, "_ena"}, {31'b0, ram_ena}, 32'd1);
    step();
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    check({tag, "_dack"}, {31'b0, d_ack}, {31'b0, exp_d});
    check({tag, "_iack"}, {31'b0, i_ack}, {31'b0, !exp_d});
    check({tag, "_ena_resp"}, {31'b0, ram_ena}, 32'd0);
    step();
  endtask

  initial begin
    logic [7:0] seq;
    rstn    = 1'b0;
    i_req   = 1'b0;
    i_addr  = 32'h0;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h10;
    d_wdata = 32'h0;
    step();
    step();
    @(negedge clk);
    check("rst_ena", {31'b0, ram_ena}, 32'd0);
    check("rst_wea", {31'b0, ram_wea}, 32'd0);
    check("rst_acks", {30'b0, i_ack, d_ack}, 32'd0);
    check("rst_errs", {30'b0, i_err, d_err}, 32'd0);
    check("rst_irdata", i_rdata, 32'd0);
    check("rst_drdata", d_rdata, 32'd0);

    // Fetch alone, first cycle out of reset
    step();
    rstn   = 1'b1;
    d_req  = 1'b0;
    d_we   = 1'b0;
    i_req  = 1'b1;
    i_addr = 32'h8;
    @(negedge clk);
    check("fetch_ena", {31'b0, ram_ena}, 32'd1);
    check("fetch_wea", {31'b0, ram_wea}, 32'd0);
    check("fetch_addr", 32'(ram_addra), 32'd2);
    step();
    i_req = 1'b0;
    @(negedge clk);
    check("fetch_ack", {31'b0, i_ack}, 32'd1);
    check("fetch_rdata", i_rdata, 32'h2402_0005);
    check("fetch_err", {31'b0, i_err}, 32'd0);
    check("fetch_dack", {31'b0, d_ack}, 32'd0);

    // Read after write
    step();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h10;
    d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wr_ena", {31'b0, ram_ena}, 32'd1);
    check("wr_wea", {31'b0, ram_wea}, 32'd1);
    check("wr_addr", 32'(ram_addra), 32'd4);
    check("wr_dina", ram_dina, 32'hDEAD_BEEF);
    step();
    d_we = 1'b0;
    @(negedge clk);
    check("wr_ack", {31'b0, d_ack}, 32'd1);
    check("wr_err", {31'b0, d_err}, 32'd0);
    step();
    @(negedge clk);
    check("rd_ena", {31'b0, ram_ena}, 32'd1);
    check("rd_wea", {31'b0, ram_wea}, 32'd0);
    step();
    @(negedge clk);
    check("rd_ack", {31'b0, d_ack}, 32'd1);
    check("rd_rdata", d_rdata, 32'hDEAD_BEEF);

    // Misaligned write must not reach RAM
    step();
    d_we    = 1'b1;
    d_addr  = 32'h13;
    d_wdata = 32'h1234_5678;
    @(negedge clk);
    check("mis_wr_ena", {31'b0, ram_ena}, 32'd0);
    step();
    d_we   = 1'b0;
    d_addr = 32'h10;
    @(negedge clk);
    check("mis_wr_ack", {31'b0, d_ack}, 32'd1);
    check("mis_wr_err", {31'b0, d_err}, 32'd1);
    step();
    step();
    @(negedge clk);
    check("mis_rd_back", d_rdata, 32'hDEAD_BEEF);
    check("mis_rd_err", {31'b0, d_err}, 32'd0);

    // Misaligned fetch
    step();
    d_req  = 1'b0;
    i_req  = 1'b1;
    i_addr = 32'h6;
    @(negedge clk);
    check("mis_i_ena", {31'b0, ram_ena}, 32'd0);
    step();
    i_req = 1'b0;
    @(negedge clk);
    check("mis_i_ack", {31'b0, i_ack}, 32'd1);
    check("mis_i_err", {31'b0, i_err}, 32'd1);

    // Aliasing
    step();
    d_req  = 1'b1;
    d_addr = 32'h0008_0010;
    @(negedge clk);
    check("alias_addr", 32'(ram_addra), 32'd4);
    step();
    d_req = 1'b0;
    @(negedge clk);
    check("alias_rdata", d_rdata, 32'hDEAD_BEEF);
    step();

    // Contention with default limit: D,D,D,I,D,D,D,I
    seq = 8'b1110_1110;
    for (int g = 0; g < 8; g++) begin
      grant_round($sformatf("cont%0d", g), 1'b1, seq[7-g]);
    end

    // Counter must clear on an IDLE cycle with i_req low
    grant_round("clr0", 1'b1, 1'b1);
    grant_round("clr1", 1'b1, 1'b1);
    grant_round("clr2", 1'b0, 1'b1);
    grant_round("clr3", 1'b1, 1'b1);
    grant_round("clr4", 1'b1, 1'b1);
    grant_round("clr5", 1'b1, 1'b1);
    grant_round("clr6", 1'b1, 1'b0);

    // Reset during RESP_D drops the ack; request is re-granted right after
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h10;
    step();
    rstn = 1'b0;
    @(negedge clk);
    check("rstmid_ack", {31'b0, d_ack}, 32'd0);
    check("rstmid_rdata", d_rdata, 32'd0);
    step();
    rstn = 1'b1;
    @(negedge clk);
    check("rstmid_regrant", {31'b0, ram_ena}, 32'd1);
    check("rstmid_addr", 32'(ram_addra), 32'd4);
    step();
    d_req = 1'b0;
    @(negedge clk);
    check("rstmid_ack2", {31'b0, d_ack}, 32'd1);
    check("rstmid_rdata2", d_rdata, 32'hDEAD_BEEF);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Structural invariants checked every cycle
  always @(negedge clk) begin
    if (rstn) begin
      check("two_acks", {31'b0, i_ack && d_ack}, 32'd0);
      check("err_wo_ack", {31'b0, (i_err && !i_ack) || (d_err && !d_ack)}, 32'd0);
      if (i_ack || d_ack) check("ena_in_resp", {31'b0, ram_ena}, 32'd0);
    end
  end

endmodule
